// File: rtl/output_buffer_80_pkg.sv
// ============================================================================
// Module   : output_buffer_80_pkg
// Purpose  : Shared sizing constants for the 80-bit xpipes output buffer.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package output_buffer_80_pkg;

    localparam int OB_FLIT_WIDTH = 80;
    localparam int OB_DEPTH      = 4;

endpackage : output_buffer_80_pkg

`default_nettype wire

// File: rtl/outbuf_regfile_80.sv
// ============================================================================
// Module   : outbuf_regfile_80
// Purpose  : DEPTH x FLIT_WIDTH flit store, one sync write port, one async read.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module outbuf_regfile_80
    import output_buffer_80_pkg::*;
#(
    parameter int FLIT_WIDTH = OB_FLIT_WIDTH,
    parameter int DEPTH      = OB_DEPTH,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [FLIT_WIDTH-1:0] wr_data,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [FLIT_WIDTH-1:0] rd_data
);

    // Contents are deliberately left unreset; validity is tracked by the count.
    logic [FLIT_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule : outbuf_regfile_80

`default_nettype wire

// File: rtl/output_buffer_80.sv
// ============================================================================
// Module   : output_buffer_80
// Purpose  : Output-port flit FIFO with stall handshake; optional empty-bypass
//            enabled by defining OUTBUF_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module output_buffer_80
    import output_buffer_80_pkg::*;
#(
    parameter int FLIT_WIDTH = OB_FLIT_WIDTH,
    parameter int DEPTH      = OB_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FLIT_WIDTH-1:0] FLIT_in,
    input  logic                  VALID_in,
    output logic                  busy_out,
    output logic [FLIT_WIDTH-1:0] FLIT_out,
    output logic                  VALID_out,
    input  logic                  STALL_in
);

    localparam int               PTR_W  = $clog2(DEPTH);
    localparam int               CNT_W  = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q,  count_d;
    logic [FLIT_WIDTH-1:0] rd_data;
    logic                  empty, full, bypass, push, pop;

    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == C_FULL);
`ifdef OUTBUF_BYPASS_EN
        // Empty and downstream ready: hand the flit straight to the link.
        bypass = empty & VALID_in & ~STALL_in;
`else
        bypass = 1'b0;
`endif
        push = VALID_in & ~full & ~bypass;
        pop  = ~empty & ~STALL_in;
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    outbuf_regfile_80 #(
        .FLIT_WIDTH (FLIT_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (PTR_W)
    ) u_regfile (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_q),
        .wr_data (FLIT_in),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_data)
    );

    assign busy_out  = full;
    assign VALID_out = ~empty | bypass;
    assign FLIT_out  = bypass ? FLIT_in : rd_data;

endmodule : output_buffer_80

`default_nettype wire
